net_cmd_sequencer: RTL and testbench



---
 rtl/net_cmd_sequencer.sv | 130 +++++++++++++
 tb/tb_net_cmd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/net_cmd_sequencer.sv
// net_cmd_sequencer: sequences network imem/dmem/PC write commands into the core.
// core_state_i encoding: 0 RUN, 1 IDLE, 2 ERR (3 unused, treated as "not RUN").
module net_cmd_sequencer #(
   parameter int ADDR_W       = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              net_v_i,
   input  logic [2:0]        net_cmd_i,
   input  logic [ADDR_W-1:0] net_addr_i,
   input  logic [31:0]       net_data_i,
   output logic              net_ready_o,
   input  logic [1:0]        core_state_i,
   input  logic              core_dmem_v_i,
   output logic              imem_w_v_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   output logic              dmem_net_sel_o,
   output logic              dmem_w_v_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [31:0]       dmem_data_o,
   output logic              core_stall_o,
   output logic              net_PC_write_cmd_IDLE_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic              bad_cmd_o
);

   localparam logic [1:0] CS_RUN  = 2'd0;
   localparam logic [1:0] CS_IDLE = 2'd1;
   localparam logic [1:0] CS_ERR  = 2'd2;

   localparam logic [2:0] CMD_NOP  = 3'd0;
   localparam logic [2:0] CMD_IMEM = 3'd1;
   localparam logic [2:0] CMD_DMEM = 3'd2;
   localparam logic [2:0] CMD_PC   = 3'd3;

   // A zero limit still needs a 1-bit counter; it simply never leaves 0.
   localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_READY,
      S_IMEM,
      S_DMEM,
      S_PC,
      S_DONE
   } seq_state_e;

   seq_state_e        state;
   logic [CW-1:0]     starve_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic              bad_q;

   logic accept;
   logic grant;
   logic dmem_go;
   logic pc_err;
   logic pc_go;

   assign net_ready_o = (state == S_READY) & ~reset;
   assign accept      = net_v_i & net_ready_o;

   // Network wins the dmem port when the core is not using it or has starved us long enough.
   assign grant   = (core_state_i != CS_RUN) | ~core_dmem_v_i | (starve_cnt == LIMIT);
   assign dmem_go = (state == S_DMEM) & grant;

   // ERR drops a pending PC write; only a clean IDLE delivers the pulse.
   assign pc_err = (state == S_PC) & (core_state_i == CS_ERR);
   assign pc_go  = (state == S_PC) & (core_state_i == CS_IDLE) & ~pc_err;

   assign imem_w_v_o     = (state == S_IMEM);
   assign imem_addr_o    = addr_q;
   assign imem_data_o    = data_q;
   assign dmem_net_sel_o = dmem_go;
   assign dmem_w_v_o     = dmem_go;
   assign dmem_addr_o    = addr_q;
   assign dmem_data_o    = data_q;
   assign core_stall_o   = dmem_go & core_dmem_v_i & (core_state_i == CS_RUN);

   assign net_PC_write_cmd_IDLE_o = pc_go;
   assign pc_o                    = addr_q;
   assign bad_cmd_o               = bad_q;

   // Command FSM: capture on handshake, then drive one strobe and return to READY.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_READY;
         starve_cnt <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         bad_q      <= 1'b0;
      end else begin
         unique case (state)
            S_READY: begin
               if (accept) begin
                  addr_q <= net_addr_i;
                  data_q <= net_data_i;
                  unique case (net_cmd_i)
                     CMD_NOP:  state <= S_DONE;
                     CMD_IMEM: state <= S_IMEM;
                     CMD_DMEM: state <= S_DMEM;
                     CMD_PC:   state <= S_PC;
                     default: begin
                        bad_q <= 1'b1;
                        state <= S_DONE;
                     end
                  endcase
               end
            end
            S_IMEM: state <= S_READY;
            S_DMEM: begin
               if (grant) begin
                  state      <= S_READY;
                  starve_cnt <= '0;
               end else if (starve_cnt != LIMIT) begin
                  starve_cnt <= starve_cnt + CW'(1);
               end
            end
            S_PC: begin
               if (pc_err || pc_go) state <= S_READY;
            end
            S_DONE:  state <= S_READY;
            default: state <= S_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_net_cmd_sequencer.sv
// tb_net_cmd_sequencer: table-driven directed vectors plus a hand-written
// reset-abort sequence for net_cmd_sequencer.
module tb_net_cmd_sequencer;

   localparam logic [1:0] RUN  = 2'd0;
   localparam logic [1:0] IDLE = 2'd1;
   localparam logic [1:0] ERR  = 2'd2;

   // Expected flag bundle: {ready, imem_w, dmem_w, sel, stall, pc_pulse, bad}
   localparam logic [6:0] E_NONE = 7'b0000000;
   localparam logic [6:0] E_RDY  = 7'b1000000;
   localparam logic [6:0] E_IM   = 7'b0100000;
   localparam logic [6:0] E_DW   = 7'b0011000;
   localparam logic [6:0] E_ST   = 7'b0000100;
   localparam logic [6:0] E_PC   = 7'b0000010;
   localparam logic [6:0] E_BAD  = 7'b0000001;

   typedef struct {
      logic        v;
      logic [2:0]  cmd;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [1:0]  cs;
      logic        dv;
      logic [6:0]  exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        net_v_i = 1'b0;
   logic [2:0]  net_cmd_i = '0;
   logic [9:0]  net_addr_i = '0;
   logic [31:0] net_data_i = '0;
   logic [1:0]  core_state_i = IDLE;
   logic        core_dmem_v_i = 1'b0;
   logic        net_ready_o;
   logic        imem_w_v_o;
   logic [9:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        dmem_net_sel_o;
   logic        dmem_w_v_o;
   logic [9:0]  dmem_addr_o;
   logic [31:0] dmem_data_o;
   logic        core_stall_o;
   logic        net_PC_write_cmd_IDLE_o;
   logic [9:0]  pc_o;
   logic        bad_cmd_o;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [9:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   vec_t        tbl[$];

   net_cmd_sequencer #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (
      .clk(clk),
      .reset(reset),
      .net_v_i(net_v_i),
      .net_cmd_i(net_cmd_i),
      .net_addr_i(net_addr_i),
      .net_data_i(net_data_i),
      .net_ready_o(net_ready_o),
      .core_state_i(core_state_i),
      .core_dmem_v_i(core_dmem_v_i),
      .imem_w_v_o(imem_w_v_o),
      .imem_addr_o(imem_addr_o),
      .imem_data_o(imem_data_o),
      .dmem_net_sel_o(dmem_net_sel_o),
      .dmem_w_v_o(dmem_w_v_o),
      .dmem_addr_o(dmem_addr_o),
      .dmem_data_o(dmem_data_o),
      .core_stall_o(core_stall_o),
      .net_PC_write_cmd_IDLE_o(net_PC_write_cmd_IDLE_o),
      .pc_o(pc_o),
      .bad_cmd_o(bad_cmd_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic v, logic [2:0] cmd, logic [9:0] a,
                               logic [31:0] d, logic [1:0] cs, logic dv,
                               logic [6:0] e);
      vec_t t;
      t.v = v; t.cmd = cmd; t.addr = a; t.data = d;
      t.cs = cs; t.dv = dv; t.exp = e;
      return t;
   endfunction

   task automatic check(input string nm, input logic [6:0] e);
      logic [6:0] got;
      got = {net_ready_o, imem_w_v_o, dmem_w_v_o, dmem_net_sel_o,
             core_stall_o, net_PC_write_cmd_IDLE_o, bad_cmd_o};
      n_vec++;
      if (got !== e ||
          imem_addr_o !== m_addr || dmem_addr_o !== m_addr || pc_o !== m_addr ||
          imem_data_o !== m_data || dmem_data_o !== m_data) begin
         n_bad++;
         $display("FAIL %s: flags got %b want %b, addr got %h/%h/%h want %h, data got %h/%h want %h",
                  nm, got, e, imem_addr_o, dmem_addr_o, pc_o, m_addr,
                  imem_data_o, dmem_data_o, m_data);
      end
   endtask

   // Drive a vector after the falling edge, compare before the rising edge.
   task automatic apply(input vec_t t, input string nm);
      @(negedge clk);
      net_v_i = t.v; net_cmd_i = t.cmd; net_addr_i = t.addr;
      net_data_i = t.data; core_state_i = t.cs; core_dmem_v_i = t.dv;
      #1;
      check(nm, t.exp);
      if (t.v && t.exp[6]) begin
         m_addr = t.addr;
         m_data = t.data;
      end
   endtask

   initial begin
      // IMEM_WR 0x005: strobe at N+1, ready again at N+2
      tbl.push_back(mk(1, 3'd1, 10'h005, 32'hDEADBEEF, IDLE, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_IM));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_RDY));
      // DMEM_WR 0x010, core RUN hogging the port: 4 denies then forced grant
      tbl.push_back(mk(1, 3'd2, 10'h010, 32'h12345678, RUN, 1, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_NONE));
      tbl.push_back(mk(1, 3'd1, 10'h003, 32'hFFFFFFFF, RUN, 1, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_DW | E_ST));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_RDY));
      // DMEM_WR with core IDLE: immediate grant, no stall
      tbl.push_back(mk(1, 3'd2, 10'h020, 32'hAAAA5555, IDLE, 1, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 1, E_DW));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 1, E_RDY));
      // DMEM_WR with core RUN but not using the port: immediate grant
      tbl.push_back(mk(1, 3'd2, 10'h021, 32'h0BADF00D, RUN, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 0, E_DW));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 0, E_RDY));
      // PC_WR 0x100: wait through 6 RUN cycles, pulse in first IDLE cycle
      tbl.push_back(mk(1, 3'd3, 10'h100, 32'h0, RUN, 0, E_RDY));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 0, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_PC));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_RDY));
      // PC_WR dropped on ERR, then a normal IMEM_WR
      tbl.push_back(mk(1, 3'd3, 10'h0AB, 32'h0, RUN, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 0, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, RUN, 0, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, ERR, 0, E_NONE));
      tbl.push_back(mk(1, 3'd1, 10'h3FF, 32'h01020304, ERR, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, ERR, 0, E_IM));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_RDY));
      // NOP: one DONE cycle, no side effect
      tbl.push_back(mk(1, 3'd0, 10'h055, 32'h55555555, IDLE, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_NONE));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_RDY));
      // Illegal command 6: sticky bad flag
      tbl.push_back(mk(1, 3'd6, 10'h066, 32'h66666666, IDLE, 0, E_RDY));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_BAD));
      tbl.push_back(mk(0, 3'd0, 10'h000, 32'h0, IDLE, 0, E_RDY | E_BAD));

      // Reset state: outputs low (ready gated by reset), captured regs zero
      @(negedge clk);
      #1;
      check("reset_state", E_NONE);
      reset = 1'b0;

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // DMEM_WR stalled by the core, reset lands in the middle of the wait
      apply(mk(1, 3'd2, 10'h0F0, 32'hCAFEBABE, RUN, 1, E_RDY | E_BAD), "rst_accept");
      apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_BAD), "rst_deny1");
      apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_BAD), "rst_deny2");
      @(negedge clk);
      #1;
      reset = 1'b1;
      m_addr = '0;
      m_data = '0;
      #1;
      check("rst_async_clear", E_NONE);
      @(negedge clk);
      #1;
      check("rst_held", E_NONE);
      reset = 1'b0;
      // Core keeps hogging: the aborted write must never appear
      for (int i = 0; i < 3; i++)
         apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_RDY), "rst_no_write");
      // Fresh DMEM_WR: starve counter restarted, so 4 full denies again
      apply(mk(1, 3'd2, 10'h1C0, 32'h89ABCDEF, RUN, 1, E_RDY), "post_accept");
      for (int i = 0; i < 4; i++)
         apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_NONE), "post_deny");
      apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_DW | E_ST), "post_grant");
      apply(mk(0, 3'd0, 10'h000, 32'h0, RUN, 1, E_RDY), "post_ready");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
